// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Collects completed results from the ALU/branch unit (A) and the load-store
//   unit (B) into two small FIFOs and drives the ROB's single writeback port,
//   serving the FIFOs round-robin, at most one result per cycle.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   flush_              active-low ROB pipeline flush (empties both FIFOs)
//   a_* / b_*           active-low source valid plus result fields
//   a_busy / b_busy     FIFO full; the source must hold its valid
//   wb_*                registered ROB writeback port (wb_e_ active-low)
//   wb_idle             both FIFOs empty and no writeback in flight
//
// The destination tag is an opaque RdWidth-bit field (ROB id plus register
// address) that passes through unchanged.
module writeback_arbiter #(
    parameter int unsigned          DATA          = 32,
    parameter int unsigned          QDEPTH        = 2,
    parameter int unsigned          RdWidth       = 10,
    parameter int unsigned          ExpWidth      = 4,
    parameter logic [ExpWidth-1:0]  ExpIMissAlign = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush_,
    input  logic                a_e_,
    input  logic [RdWidth-1:0]  a_rd,
    input  logic [DATA-1:0]     a_data,
    input  logic                a_exp_,
    input  logic [ExpWidth-1:0] a_exp_code,
    input  logic                a_pred_miss_,
    input  logic                a_jump_miss_,
    input  logic                b_e_,
    input  logic [RdWidth-1:0]  b_rd,
    input  logic [DATA-1:0]     b_data,
    input  logic                b_exp_,
    input  logic [ExpWidth-1:0] b_exp_code,
    input  logic                b_pred_miss_,
    input  logic                b_jump_miss_,
    output logic                a_busy,
    output logic                b_busy,
    output logic                wb_e_,
    output logic [RdWidth-1:0]  wb_rd,
    output logic [DATA-1:0]     wb_data,
    output logic                wb_exp_,
    output logic [ExpWidth-1:0] wb_exp_code,
    output logic                wb_pred_miss_,
    output logic                wb_jump_miss_,
    output logic                wb_idle
);

    localparam logic        Disable_ = 1'b1;
    localparam logic        Enable_  = 1'b0;
    localparam int unsigned PtrW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned EntW     = RdWidth + DATA + ExpWidth + 3;
    localparam logic [PtrW:0] Full   = QDEPTH[PtrW:0];

    typedef logic [EntW-1:0] entry_t;

    // Index 0 is source A, index 1 is source B.
    entry_t          mem_q  [2][QDEPTH];
    logic [PtrW-1:0] wptr_q [2];
    logic [PtrW-1:0] rptr_q [2];
    logic [PtrW:0]   cnt_q  [2];
    logic            prio_q;  // 0 = A wins a tie, 1 = B wins a tie

    entry_t     in_ent [2];
    entry_t     head;
    logic [1:0] in_e_;
    logic [1:0] busy;
    logic [1:0] nonempty;
    logic [1:0] push;
    logic [1:0] pop;

    always_comb begin
        in_ent[0] = {a_rd, a_data, a_exp_, a_exp_code, a_pred_miss_, a_jump_miss_};
        in_ent[1] = {b_rd, b_data, b_exp_, b_exp_code, b_pred_miss_, b_jump_miss_};
        in_e_     = {b_e_, a_e_};
        busy      = '0;
        nonempty  = '0;
        push      = '0;
        for (int s = 0; s < 2; s++) begin
            // Busy uses the registered count only; no look-ahead to a same-cycle pop.
            busy[s]     = (cnt_q[s] == Full);
            nonempty[s] = (cnt_q[s] != '0);
            push[s]     = flush_ && !in_e_[s] && !busy[s];
        end
        // A flush edge suppresses any grant.
        pop[0] = flush_ && nonempty[0] && (!nonempty[1] || !prio_q);
        pop[1] = flush_ && nonempty[1] && (!nonempty[0] || prio_q);
        head   = pop[1] ? mem_q[1][rptr_q[1]] : mem_q[0][rptr_q[0]];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                wptr_q[s] <= '0;
                rptr_q[s] <= '0;
                cnt_q[s]  <= '0;
            end
            prio_q <= 1'b0;
        end else if (!flush_) begin
            // Priority survives a flush.
            for (int s = 0; s < 2; s++) begin
                wptr_q[s] <= '0;
                rptr_q[s] <= '0;
                cnt_q[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) wptr_q[s] <= wptr_q[s] + 1'b1;
                if (pop[s])  rptr_q[s] <= rptr_q[s] + 1'b1;
                if (push[s] && !pop[s]) begin
                    cnt_q[s] <= cnt_q[s] + 1'b1;
                end else if (pop[s] && !push[s]) begin
                    cnt_q[s] <= cnt_q[s] - 1'b1;
                end
            end
            if (pop[0]) begin
                prio_q <= 1'b1;
            end else if (pop[1]) begin
                prio_q <= 1'b0;
            end
        end
    end

    // Storage needs no reset: count and pointers define what is valid.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) mem_q[s][wptr_q[s]] <= in_ent[s];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_e_         <= Disable_;
            wb_rd         <= '0;
            wb_data       <= '0;
            wb_exp_       <= Disable_;
            wb_exp_code   <= ExpIMissAlign;
            wb_pred_miss_ <= Disable_;
            wb_jump_miss_ <= Disable_;
        end else if (pop != 2'b00) begin
            wb_e_ <= Enable_;
            {wb_rd, wb_data, wb_exp_, wb_exp_code, wb_pred_miss_, wb_jump_miss_} <= head;
        end else begin
            wb_e_         <= Disable_;
            wb_rd         <= '0;
            wb_data       <= '0;
            wb_exp_       <= Disable_;
            wb_exp_code   <= ExpIMissAlign;
            wb_pred_miss_ <= Disable_;
            wb_jump_miss_ <= Disable_;
        end
    end

    assign a_busy  = busy[0];
    assign b_busy  = busy[1];
    assign wb_idle = !nonempty[0] && !nonempty[1] && (wb_e_ == Disable_);

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter
//   Self-checking bench for writeback_arbiter. A queue-level reference model
//   tracks each source FIFO, the round-robin priority and the expected
//   writeback beats; a monitor on the falling edge pops and compares.
module tb_writeback_arbiter;

    localparam int unsigned DATA   = 32;
    localparam int unsigned QDEPTH = 2;
    localparam int unsigned RdW    = 10;
    localparam int unsigned ExpW   = 4;
    localparam logic [ExpW-1:0] EXP_I_MISS_ALIGN = 4'd0;

    typedef struct packed {
        logic [RdW-1:0]  rd;
        logic [DATA-1:0] data;
        logic            exp_;
        logic [ExpW-1:0] exp_code;
        logic            pred_miss_;
        logic            jump_miss_;
    } ent_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            flush_ = 1'b1;
    logic            a_e_ = 1'b1, b_e_ = 1'b1;
    logic [RdW-1:0]  a_rd = '0, b_rd = '0;
    logic [DATA-1:0] a_data = '0, b_data = '0;
    logic            a_exp_ = 1'b1, b_exp_ = 1'b1;
    logic [ExpW-1:0] a_exp_code = '0, b_exp_code = '0;
    logic            a_pred_miss_ = 1'b1, b_pred_miss_ = 1'b1;
    logic            a_jump_miss_ = 1'b1, b_jump_miss_ = 1'b1;
    logic            a_busy, b_busy, wb_e_, wb_exp_, wb_pred_miss_, wb_jump_miss_, wb_idle;
    logic [RdW-1:0]  wb_rd;
    logic [DATA-1:0] wb_data;
    logic [ExpW-1:0] wb_exp_code;

    always #5 clk = ~clk;

    writeback_arbiter #(
        .DATA(DATA), .QDEPTH(QDEPTH), .RdWidth(RdW), .ExpWidth(ExpW),
        .ExpIMissAlign(EXP_I_MISS_ALIGN)
    ) dut (
        .clk(clk), .reset(reset), .flush_(flush_),
        .a_e_(a_e_), .a_rd(a_rd), .a_data(a_data), .a_exp_(a_exp_),
        .a_exp_code(a_exp_code), .a_pred_miss_(a_pred_miss_), .a_jump_miss_(a_jump_miss_),
        .b_e_(b_e_), .b_rd(b_rd), .b_data(b_data), .b_exp_(b_exp_),
        .b_exp_code(b_exp_code), .b_pred_miss_(b_pred_miss_), .b_jump_miss_(b_jump_miss_),
        .a_busy(a_busy), .b_busy(b_busy),
        .wb_e_(wb_e_), .wb_rd(wb_rd), .wb_data(wb_data), .wb_exp_(wb_exp_),
        .wb_exp_code(wb_exp_code), .wb_pred_miss_(wb_pred_miss_),
        .wb_jump_miss_(wb_jump_miss_), .wb_idle(wb_idle)
    );

    // Stimulus queues (what each source still wants to send).
    ent_t sa[$], sb[$];
    // Reference model: FIFO contents, priority, expected writeback beats.
    ent_t qa[$], qb[$], sbq[$];
    bit   prio = 1'b0;
    bit   acc_a = 1'b0, acc_b = 1'b0;
    bit   exp_busy_a = 1'b0, exp_busy_b = 1'b0, exp_idle = 1'b1;
    int   total = 0, bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic ent_t mk(input logic [RdW-1:0] rd, input logic [DATA-1:0] d,
                                input logic e, input logic [ExpW-1:0] c,
                                input logic p, input logic j);
        ent_t x;
        x.rd = rd; x.data = d; x.exp_ = e; x.exp_code = c; x.pred_miss_ = p; x.jump_miss_ = j;
        return x;
    endfunction

    function automatic ent_t rnd_ent();
        return mk(RdW'($urandom), $urandom, ($urandom_range(0, 3) != 0), ExpW'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    endfunction

    task automatic check_reset_outs(input string tag);
        check({tag, " wb_e_"}, wb_e_, 1'b1);
        check({tag, " wb_rd"}, wb_rd, '0);
        check({tag, " wb_data"}, wb_data, '0);
        check({tag, " wb_exp_"}, wb_exp_, 1'b1);
        check({tag, " wb_exp_code"}, wb_exp_code, EXP_I_MISS_ALIGN);
        check({tag, " wb_pred_miss_"}, wb_pred_miss_, 1'b1);
        check({tag, " wb_jump_miss_"}, wb_jump_miss_, 1'b1);
        check({tag, " a_busy"}, a_busy, 1'b0);
        check({tag, " b_busy"}, b_busy, 1'b0);
        check({tag, " wb_idle"}, wb_idle, 1'b1);
    endtask

    // One clock of stimulus; sources hold their head until the model accepts it.
    task automatic cycle(input bit do_flush);
        if (sa.size() > 0) begin
            a_e_ = 1'b0;
            {a_rd, a_data, a_exp_, a_exp_code, a_pred_miss_, a_jump_miss_} = sa[0];
        end else begin
            a_e_ = 1'b1;
        end
        if (sb.size() > 0) begin
            b_e_ = 1'b0;
            {b_rd, b_data, b_exp_, b_exp_code, b_pred_miss_, b_jump_miss_} = sb[0];
        end else begin
            b_e_ = 1'b1;
        end
        flush_ = do_flush ? 1'b0 : 1'b1;
        @(posedge clk);
        #1;
        if (acc_a) void'(sa.pop_front());
        if (acc_b) void'(sb.pop_front());
        flush_ = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle(1'b0);
    endtask

    // Reference model, evaluated at every rising edge.
    initial begin
        ent_t cur_a, cur_b;
        bit   ga, gb;
        forever begin
            @(posedge clk);
            if (reset) begin
                qa.delete(); qb.delete(); prio = 1'b0;
                acc_a = 1'b0; acc_b = 1'b0;
                exp_busy_a = 1'b0; exp_busy_b = 1'b0; exp_idle = 1'b1;
            end else begin
                cur_a = {a_rd, a_data, a_exp_, a_exp_code, a_pred_miss_, a_jump_miss_};
                cur_b = {b_rd, b_data, b_exp_, b_exp_code, b_pred_miss_, b_jump_miss_};
                ga = 1'b0; gb = 1'b0;
                if (flush_) begin
                    if (qa.size() > 0 && (qb.size() == 0 || prio == 1'b0)) ga = 1'b1;
                    else if (qb.size() > 0) gb = 1'b1;
                end
                // Acceptance depends on occupancy before this edge.
                acc_a = flush_ && !a_e_ && (qa.size() < QDEPTH);
                acc_b = flush_ && !b_e_ && (qb.size() < QDEPTH);
                if (!flush_) begin
                    qa.delete(); qb.delete();
                end else begin
                    if (ga) begin sbq.push_back(qa.pop_front()); prio = 1'b1; end
                    if (gb) begin sbq.push_back(qb.pop_front()); prio = 1'b0; end
                    if (acc_a) qa.push_back(cur_a);
                    if (acc_b) qb.push_back(cur_b);
                end
                exp_busy_a = (qa.size() == QDEPTH);
                exp_busy_b = (qb.size() == QDEPTH);
                exp_idle   = (qa.size() == 0) && (qb.size() == 0) && !ga && !gb;
            end
        end
    end

    // Monitor: compares the writeback port against the scoreboard each cycle.
    initial begin
        ent_t got, want;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("a_busy", a_busy, exp_busy_a);
                check("b_busy", b_busy, exp_busy_b);
                check("wb_idle", wb_idle, exp_idle);
                check("wb_e_", wb_e_, (sbq.size() == 0) ? 1'b1 : 1'b0);
                if (sbq.size() > 0) begin
                    want = sbq.pop_front();
                    if (wb_e_ == 1'b0) begin
                        got = {wb_rd, wb_data, wb_exp_, wb_exp_code, wb_pred_miss_, wb_jump_miss_};
                        check("wb beat", got, want);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_outs("reset");
        reset = 1'b0;

        // Single result from A.
        sa.push_back(mk(10'd1, 32'haaaa, 1'b1, 4'd0, 1'b1, 1'b1));
        run(5);

        // Contention: both sources backlogged; expect A0 B0 A1 B1 A2 B2.
        for (int i = 0; i < 3; i++) begin
            sa.push_back(mk(10'd4, 32'hA0 + i, 1'b1, 4'd0, 1'b1, 1'b1));
            sb.push_back(mk(10'd5, 32'hB0 + i, 1'b1, 4'd0, 1'b1, 1'b1));
        end
        run(10);

        // Exception and mispredict pass-through.
        sb.push_back(mk(10'd2, 32'h1234, 1'b0, EXP_I_MISS_ALIGN, 1'b1, 1'b1));
        sa.push_back(mk(10'd3, 32'h5678, 1'b1, 4'd0, 1'b0, 1'b1));
        run(6);

        // Flush while queues are loaded and A presents a new entry.
        for (int i = 0; i < 4; i++) begin
            sa.push_back(mk(10'd6, 32'hC0 + i, 1'b1, 4'd0, 1'b1, 1'b1));
            sb.push_back(mk(10'd7, 32'hD0 + i, 1'b1, 4'd0, 1'b1, 1'b1));
        end
        run(2);
        sa.push_front(mk(10'd8, 32'hdead, 1'b1, 4'd0, 1'b1, 1'b1));
        cycle(1'b1);
        sa.delete(); sb.delete();
        run(4);
        check("post-flush a_busy", a_busy, 1'b0);
        check("post-flush b_busy", b_busy, 1'b0);
        check("post-flush wb_idle", wb_idle, 1'b1);

        // Full boundary: A alone, enqueue on the same edge its head is granted.
        for (int i = 0; i < 4; i++) sa.push_back(mk(10'd9, 32'hE0 + i, 1'b1, 4'd0, 1'b1, 1'b1));
        run(8);

        // Asynchronous reset while a writeback beat is on the port.
        for (int i = 0; i < 3; i++) begin
            sa.push_back(mk(10'd10, 32'hF0 + i, 1'b1, 4'd0, 1'b1, 1'b1));
            sb.push_back(mk(10'd11, 32'hF8 + i, 1'b1, 4'd0, 1'b1, 1'b1));
        end
        run(3);
        check("pre-reset wb_e_", wb_e_, (sbq.size() == 0) ? 1'b1 : 1'b0);
        #2;
        reset = 1'b1;
        a_e_ = 1'b1; b_e_ = 1'b1;
        sa.delete(); sb.delete(); qa.delete(); qb.delete(); sbq.delete();
        prio = 1'b0; acc_a = 1'b0; acc_b = 1'b0;
        exp_busy_a = 1'b0; exp_busy_b = 1'b0; exp_idle = 1'b1;
        #1;
        check_reset_outs("async reset");
        @(negedge clk);
        #1;
        reset = 1'b0;
        // First contention after reset must grant A.
        sa.push_back(mk(10'd12, 32'h0A0A, 1'b1, 4'd0, 1'b1, 1'b1));
        sb.push_back(mk(10'd13, 32'h0B0B, 1'b1, 4'd0, 1'b1, 1'b1));
        run(5);

        // Randomized traffic with occasional flushes.
        repeat (300) begin
            if (sa.size() < 3 && $urandom_range(0, 2) != 0) sa.push_back(rnd_ent());
            if (sb.size() < 3 && $urandom_range(0, 2) != 0) sb.push_back(rnd_ent());
            cycle($urandom_range(0, 39) == 0);
        end
        run(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Collects completed results from the two execution sources, the ALU/branch unit (A) and the load-store unit (B), and drives the reorder buffer's single writeback port. It delivers at most one result per cycle. Each source has a small FIFO with busy backpressure, and the two FIFOs are served round-robin. A pipeline flush from the ROB discards everything queued.

## Interface
Parameters:
- DATA, `DataWidth`, result data width
- QDEPTH, 2, entries per source FIFO (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- flush_  in  1  active-low; ROB pipeline flush
- a_e_ / b_e_  in  1  active-low source valid
- a_rd / b_rd  in  RegFile_t  destination tag carrying the ROB id; passed through unchanged
- a_data / b_data  in  DATA  result value
- a_exp_ / b_exp_  in  1  active-low exception flag
- a_exp_code / b_exp_code  in  ExpCode_t  exception code
- a_pred_miss_ / b_pred_miss_  in  1  active-low branch mispredict
- a_jump_miss_ / b_jump_miss_  in  1  active-low jump target miss
- a_busy / b_busy  out  1  high = FIFO full; source must hold
- wb_e_, wb_rd, wb_data, wb_exp_, wb_exp_code, wb_pred_miss_, wb_jump_miss_  out  same widths as source fields  ROB writeback port
- wb_idle  out  1  high when both FIFOs are empty and wb_e_ is disabled

## Operation
- **Per-source FIFO:** QDEPTH entries, each holding {rd, data, exp_, exp_code, pred_miss_, jump_miss_}.
- **Pointers and count:** read and write pointers are log2(QDEPTH) bits and wrap modulo QDEPTH. The count is log2(QDEPTH)+1 bits.
- **Enqueue:** happens when x_e_ is enabled and x_busy is low.
  - A valid presented while busy is ignored. The source must hold it until busy drops.
  - x_busy = (count == QDEPTH). It is derived from the registered count and does not look ahead to a same-cycle dequeue.
- **Arbitration:** combinational on the FIFO heads, one grant per cycle.
  - Only A non-empty: grant A. Only B non-empty: grant B.
  - Both non-empty: grant the source named by the priority bit `prio`.
  - After any grant, prio points to the source that was not granted.
  - Reset value: prio = A.
- **Output:** the granted head is dequeued and loaded into the wb_* output registers. wb_e_ is enabled for exactly one cycle per entry.
  - With no grant, wb_e_ is disabled and the other wb_* fields are set to their reset values.
- **Simultaneous enqueue and dequeue on one FIFO:** the count is unchanged. When count == QDEPTH-1, the enqueue is accepted.
- **Flush (flush_ enabled at an edge):**
  - Both FIFOs are emptied (pointers and count return to 0).
  - Inputs presented that cycle are dropped.
  - No grant is made; wb_e_ is disabled from the next cycle.
  - prio is unchanged.
- **Reset (asynchronous, mid-operation):**
  - All queued entries are lost, prio returns to A, and outputs go to their reset values immediately.
  - Output reset values: wb_e_ = `Disable_`, wb_rd = 0, wb_data = 0, wb_exp_ = `Disable_`, wb_exp_code = EXP_I_MISS_ALIGN, wb_pred_miss_ = `Disable_`, wb_jump_miss_ = `Disable_`, a_busy = b_busy = 0, wb_idle = 1.

## Timing
- **Latency:** an entry sampled at edge k appears on wb_* during the cycle after edge k+1, provided it is granted at k+1. Minimum latency is 2 edges.
- **Throughput:** one writeback per cycle in total. With both sources continuously backlogged, each source gets 50%, alternating A, B, A, B.
- **Recovery after full:** x_busy falls in the cycle after the dequeue edge, so a full FIFO accepts again one cycle after its head is granted.
- **Flush with a pending grant:** if a grant would coincide with a flush edge, the flush wins and nothing is written back.

## Test plan
- **Single result:** A presents rd.addr=1, data=0xaaaa at edge 1. Required: wb_e_ enabled during the cycle after edge 2 with wb_data=0xaaaa and wb_rd.addr=1, then disabled; wb_idle returns to 1.
- **Contention:** A and B each enqueue 3 entries (data 0xA0..0xA2 and 0xB0..0xB2) back to back from reset, holding while busy. Required: wb order A0, B0, A1, B1, A2, B2 on consecutive cycles; each busy asserts after 2 accepted entries; no entry lost or duplicated.
- **Exception/miss pass-through:** B sends exp_ enabled with code EXP_I_MISS_ALIGN; A sends pred_miss_ enabled with rd.addr=3. Required: each flag appears only in its own wb beat, and all other flags in that beat read `Disable_`.
- **Flush:** fill both FIFOs (2 each), then assert flush_ for one edge while A also presents a new entry. Required: no wb_e_ enabled afterwards, busy=0, wb_idle=1, and the new entry is not written back.
- **Reset mid-stream:** assert reset asynchronously between edges while wb_e_ is enabled. Required: wb_e_ disabled and all outputs at reset values without waiting for a clock edge; the first post-reset contention grants A.
- **Full boundary:** with A at count 1, present a new entry on the same edge A's head is granted. Required: entry accepted, a_busy stays 0, entries drain in FIFO order.
